// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame engine.
// State encoding, frame limits and majority-vote sample positions.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    localparam int TIMEOUT_BITS  = 40;
    localparam int MIN_DATA_BITS = 5;

    // Vote offsets relative to the bit midpoint OVS/2.
    localparam int VOTE_FIRST = -1;
    localparam int VOTE_MID   = 0;
    localparam int VOTE_LAST  = 1;

    function automatic int vote_pos(input int ovs, input int ofs);
        return ovs / 2 + ofs;
    endfunction

    function automatic logic [3:0] clamp_bits(
        input logic [3:0] req,
        input int         dmax
    );
        if (int'(req) < MIN_DATA_BITS) return 4'(MIN_DATA_BITS);
        if (int'(req) > dmax) return 4'(dmax);
        return req;
    endfunction

endpackage

// File: rtl/uart_rx_frame_engine_if.sv
// Line, configuration and output-register signals of the UART RX engine.
// master: line/config driver and consumer; slave: the receive engine.
interface uart_rx_frame_engine_if #(
    parameter int DATA_MAX = 9
);
    logic                enable;
    logic                sample_tick;
    logic                rxd;
    logic [3:0]          cfg_data_bits;
    logic                cfg_parity_en;
    logic                cfg_parity_odd;
    logic                cfg_stop2;
    logic [DATA_MAX-1:0] rx_data;
    logic                rx_valid;
    logic                rx_ready;
    logic                err_parity;
    logic                err_frame;
    logic                err_overrun;
    logic                rx_break;
    logic                rx_timeout;
    logic                busy;

    modport master (
        output enable, sample_tick, rxd,
        output cfg_data_bits, cfg_parity_en,
        output cfg_parity_odd, cfg_stop2, rx_ready,
        input  rx_data, rx_valid, err_parity,
        input  err_frame, err_overrun, rx_break,
        input  rx_timeout, busy
    );

    modport slave (
        input  enable, sample_tick, rxd,
        input  cfg_data_bits, cfg_parity_en,
        input  cfg_parity_odd, cfg_stop2, rx_ready,
        output rx_data, rx_valid, err_parity,
        output err_frame, err_overrun, rx_break,
        output rx_timeout, busy
    );
endinterface

// File: rtl/uart_rx_majority_vote.sv
// Captures three oversamples around the bit midpoint and resolves
// a 2-of-3 majority on the third sample tick (resolve_o strobe).
module uart_rx_majority_vote
    import uart_rx_pkg::*;
#(
    parameter int OVS = 16,
    parameter int CW  = $clog2(OVS)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          tick_i,
    input  logic [CW-1:0] cnt_i,
    input  logic          bit_i,
    output logic          bit_val_o,
    output logic          resolve_o
);
    localparam logic [CW-1:0] P0 = CW'(vote_pos(OVS, VOTE_FIRST));
    localparam logic [CW-1:0] P1 = CW'(vote_pos(OVS, VOTE_MID));
    localparam logic [CW-1:0] P2 = CW'(vote_pos(OVS, VOTE_LAST));

    logic [1:0] s_q;

    // Hold the first two samples of the current bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s_q <= 2'b11;
        end else if (tick_i) begin
            if (cnt_i == P0) s_q[0] <= bit_i;
            if (cnt_i == P1) s_q[1] <= bit_i;
        end
    end

    assign resolve_o = tick_i && (cnt_i == P2);
    assign bit_val_o = (s_q[0] & s_q[1]) |
                       (s_q[0] & bit_i) |
                       (s_q[1] & bit_i);
endmodule

// File: rtl/uart_rx_frame_engine.sv
// UART receive engine: start detect, voted bit sampling, frame checks,
// break detect, output register. Optional idle timeout: UART_RX_TIMEOUT_EN.
module uart_rx_frame_engine
    import uart_rx_pkg::*;
#(
    parameter int DATA_MAX    = 9,
    parameter int OVS         = 16,
    parameter int SYNC_STAGES = 2
) (
    input logic pclk,
    input logic preset,
    uart_rx_frame_engine_if.slave bus
);
    localparam int CW = $clog2(OVS);
    localparam int BW = $clog2(DATA_MAX);

    rx_state_e           state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]       tick_q, tick_d, tick_nx;
    logic [BW-1:0]       bit_q, bit_d;
    logic                stop_q, stop_d;
    logic [DATA_MAX-1:0] shreg_q, shreg_d;
    logic                perr_q, perr_d;
    logic                ferr_q, ferr_d;
    logic                zero_q, zero_d;
    logic [3:0]          nbits_q, nbits_d;
    logic                pen_q, pen_d;
    logic                podd_q, podd_d;
    logic                s2_q, s2_d;
    logic                rxd_s, tick, last_tick;
    logic                bit_val, resolve, load;

    logic [DATA_MAX-1:0] data_q;
    logic                valid_q, ep_q, ef_q, ovr_q;

    assign rxd_s     = sync_q[SYNC_STAGES-1];
    assign tick      = bus.sample_tick;
    assign last_tick = (tick_q == CW'(OVS - 1));
    assign tick_nx   = last_tick ? '0 : tick_q + CW'(1);

    // Bring the asynchronous line into the pclk domain.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) sync_q <= '1;
        else sync_q <= {sync_q[SYNC_STAGES-2:0], bus.rxd};
    end

    uart_rx_majority_vote #(.OVS(OVS), .CW(CW)) u_vote (
        .clk_i     (pclk),
        .rst_i     (preset),
        .tick_i    (tick),
        .cnt_i     (tick_q),
        .bit_i     (rxd_s),
        .bit_val_o (bit_val),
        .resolve_o (resolve)
    );

    // Frame state register and per-frame working registers.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q <= ST_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shreg_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            zero_q  <= 1'b0;
            nbits_q <= '0;
            pen_q   <= 1'b0;
            podd_q  <= 1'b0;
            s2_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shreg_q <= shreg_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            zero_q  <= zero_d;
            nbits_q <= nbits_d;
            pen_q   <= pen_d;
            podd_q  <= podd_d;
            s2_q    <= s2_d;
        end
    end

    // Next-state: walk the frame one oversample tick at a time.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        shreg_d = shreg_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        zero_d  = zero_q;
        nbits_d = nbits_q;
        pen_d   = pen_q;
        podd_d  = podd_q;
        s2_d    = s2_q;
        load    = 1'b0;
        if (!bus.enable) begin
            state_d = ST_IDLE;
            tick_d  = '0;
            bit_d   = '0;
            stop_d  = 1'b0;
        end else if (tick) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!rxd_s) begin
                        state_d = ST_START;
                        tick_d  = '0;
                        bit_d   = '0;
                        stop_d  = 1'b0;
                        shreg_d = '0;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                        zero_d  = 1'b1;
                        nbits_d = clamp_bits(bus.cfg_data_bits, DATA_MAX);
                        pen_d   = bus.cfg_parity_en;
                        podd_d  = bus.cfg_parity_odd;
                        s2_d    = bus.cfg_stop2;
                    end
                end
                ST_START: begin
                    tick_d = tick_nx;
                    if (resolve && bit_val) begin
                        state_d = ST_IDLE;
                        tick_d  = '0;
                    end else if (last_tick) begin
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    tick_d = tick_nx;
                    if (resolve) begin
                        shreg_d[bit_q] = bit_val;
                        if (bit_val) zero_d = 1'b0;
                    end
                    if (last_tick) begin
                        if (bit_q == BW'(nbits_q - 4'd1)) begin
                            bit_d   = '0;
                            state_d = pen_q ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    tick_d = tick_nx;
                    if (resolve) begin
                        if (bit_val != (^shreg_q ^ podd_q)) perr_d = 1'b1;
                        if (bit_val) zero_d = 1'b0;
                    end
                    if (last_tick) state_d = ST_STOP;
                end
                ST_STOP: begin
                    tick_d = tick_nx;
                    if (resolve) begin
                        if (!stop_q && zero_q && !bit_val) begin
                            state_d = ST_BREAK;
                        end else begin
                            ferr_d = ferr_q | ~bit_val;
                            if (!s2_q || stop_q) begin
                                load    = 1'b1;
                                state_d = ST_IDLE;
                                tick_d  = '0;
                                stop_d  = 1'b0;
                            end
                        end
                    end else if (last_tick) begin
                        stop_d = 1'b1;
                    end
                end
                ST_BREAK: begin
                    tick_d = tick_nx;
                    if (resolve && bit_val) begin
                        state_d = ST_IDLE;
                        tick_d  = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output register: hold until handshake, drop frames that collide.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ep_q    <= 1'b0;
            ef_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            if (load) begin
                if (!valid_q || bus.rx_ready) begin
                    data_q  <= shreg_q;
                    ep_q    <= perr_q;
                    ef_q    <= ferr_d;
                    valid_q <= 1'b1;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (valid_q && bus.rx_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

`ifdef UART_RX_TIMEOUT_EN
    logic [CW-1:0] itick_q;
    logic [5:0]    ibits_q;
    logic          armed_q, tout_q;

    // Count idle bit periods; fire once per armed idle stretch.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            itick_q <= '0;
            ibits_q <= '0;
            armed_q <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            tout_q <= 1'b0;
            if (load) armed_q <= 1'b1;
            if (state_q != ST_IDLE) begin
                itick_q <= '0;
                ibits_q <= '0;
            end else if (bus.enable && tick && rxd_s &&
                         ibits_q < 6'(TIMEOUT_BITS)) begin
                if (itick_q == CW'(OVS - 1)) begin
                    itick_q <= '0;
                    ibits_q <= ibits_q + 6'd1;
                    if (ibits_q == 6'(TIMEOUT_BITS - 1) && armed_q) begin
                        tout_q  <= 1'b1;
                        armed_q <= 1'b0;
                    end
                end else begin
                    itick_q <= itick_q + CW'(1);
                end
            end
        end
    end

    assign bus.rx_timeout = tout_q;
`else
    assign bus.rx_timeout = 1'b0;
`endif

    assign bus.rx_data     = data_q;
    assign bus.rx_valid    = valid_q;
    assign bus.err_parity  = ep_q;
    assign bus.err_frame   = ef_q;
    assign bus.err_overrun = ovr_q;
    assign bus.rx_break    = (state_q == ST_BREAK);
    assign bus.busy        = (state_q != ST_IDLE);
endmodule

// File: tb/tb_uart_rx_frame_engine.sv
// Directed bench for uart_rx_frame_engine: frame table plus glitch,
// overrun, break, enable-drop and (UART_RX_TIMEOUT_EN) timeout sequences.
module tb_uart_rx_frame_engine;
    localparam int DMAX = 9;
    localparam int TDIV = 4;
    localparam int BITC = 16 * TDIV;

    typedef struct {
        int         cfg_bits;
        int         send_bits;
        logic [8:0] data;
        bit         pen;
        bit         podd;
        bit         badp;
        bit         s2;
        bit [1:0]   slow;
        logic [8:0] exp_data;
        bit         exp_pe;
        bit         exp_fe;
    } vec_t;

    logic pclk = 1'b0;
    logic preset = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   ovr_cnt = 0;
    int   brk_cnt = 0;
    int   tout_cnt = 0;
    bit   busy_seen = 0;
    bit   brk_prev = 0;

    uart_rx_frame_engine_if #(.DATA_MAX(DMAX)) bus_if ();

    uart_rx_frame_engine #(
        .DATA_MAX(DMAX), .OVS(16), .SYNC_STAGES(2)
    ) dut (
        .pclk   (pclk),
        .preset (preset),
        .bus    (bus_if)
    );

    always #5 pclk = ~pclk;

    initial begin
        int tdiv;
        tdiv = 0;
        bus_if.sample_tick = 1'b0;
        forever begin
            @(negedge pclk);
            tdiv = (tdiv + 1) % TDIV;
            bus_if.sample_tick = (tdiv == 0);
        end
    end

    always @(negedge pclk) begin
        if (bus_if.err_overrun) ovr_cnt++;
        if (bus_if.rx_timeout) tout_cnt++;
        if (bus_if.busy) busy_seen = 1;
        if (bus_if.rx_break && !brk_prev) brk_cnt++;
        brk_prev = bus_if.rx_break;
    end

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic bits(input logic v, input int n);
        bus_if.rxd = v;
        repeat (n * BITC) @(negedge pclk);
    endtask

    task automatic set_cfg(input int nb, input bit pen,
                           input bit podd, input bit s2);
        bus_if.cfg_data_bits  = 4'(nb);
        bus_if.cfg_parity_en  = pen;
        bus_if.cfg_parity_odd = podd;
        bus_if.cfg_stop2      = s2;
    endtask

    task automatic send(input vec_t v);
        logic p;
        p = v.podd ^ v.badp;
        bits(1'b0, 1);
        for (int i = 0; i < v.send_bits; i++) begin
            bits(v.data[i], 1);
            p ^= v.data[i];
        end
        if (v.pen) bits(p, 1);
        bits(!v.slow[0], 1);
        if (v.s2) bits(!v.slow[1], 1);
        bits(1'b1, 1);
    endtask

    task automatic handshake(input string nm);
        @(negedge pclk);
        bus_if.rx_ready = 1'b1;
        @(negedge pclk);
        bus_if.rx_ready = 1'b0;
        check({nm, "_vclr"}, int'(bus_if.rx_valid), 0);
    endtask

    function automatic vec_t mk(input int cb, input int sb,
                                input logic [8:0] d, input bit pen,
                                input bit podd, input bit badp,
                                input bit s2, input bit [1:0] sl,
                                input logic [8:0] ed, input bit pe,
                                input bit fe);
        vec_t v;
        v.cfg_bits = cb; v.send_bits = sb; v.data = d;
        v.pen = pen; v.podd = podd; v.badp = badp; v.s2 = s2;
        v.slow = sl; v.exp_data = ed; v.exp_pe = pe; v.exp_fe = fe;
        return v;
    endfunction

    initial begin
        vec_t vt[12];
        vec_t v;
        int   o0, b0, t0;

        vt[0]  = mk(8, 8, 9'h0A5, 0, 0, 0, 0, 2'b00, 9'h0A5, 0, 0);
        vt[1]  = mk(7, 7, 9'h03C, 1, 1, 1, 1, 2'b00, 9'h03C, 1, 0);
        vt[2]  = mk(8, 8, 9'h05A, 1, 0, 0, 0, 2'b00, 9'h05A, 0, 0);
        vt[3]  = mk(5, 5, 9'h01F, 0, 0, 0, 0, 2'b00, 9'h01F, 0, 0);
        vt[4]  = mk(9, 9, 9'h155, 0, 0, 0, 0, 2'b00, 9'h155, 0, 0);
        vt[5]  = mk(8, 8, 9'h081, 0, 0, 0, 0, 2'b01, 9'h081, 0, 1);
        vt[6]  = mk(3, 5, 9'h015, 0, 0, 0, 0, 2'b00, 9'h015, 0, 0);
        vt[7]  = mk(8, 8, 9'h000, 1, 1, 0, 0, 2'b00, 9'h000, 0, 0);
        vt[8]  = mk(12, 9, 9'h1C3, 1, 0, 0, 0, 2'b00, 9'h1C3, 0, 0);
        vt[9]  = mk(6, 6, 9'h02A, 0, 0, 0, 1, 2'b10, 9'h02A, 0, 1);
        vt[10] = mk(9, 9, 9'h101, 1, 0, 1, 0, 2'b00, 9'h101, 1, 0);
        vt[11] = mk(8, 8, 9'h0FF, 1, 1, 0, 1, 2'b11, 9'h0FF, 0, 1);

        bus_if.enable = 1'b0;
        bus_if.rxd = 1'b1;
        bus_if.rx_ready = 1'b0;
        set_cfg(8, 0, 0, 0);
        repeat (4) @(negedge pclk);
        check("rst_valid", int'(bus_if.rx_valid), 0);
        check("rst_data", int'(bus_if.rx_data), 0);
        check("rst_busy", int'(bus_if.busy), 0);
        check("rst_break", int'(bus_if.rx_break), 0);
        check("rst_ovr", int'(bus_if.err_overrun), 0);
        preset = 1'b0;
        repeat (4) @(negedge pclk);
        bus_if.enable = 1'b1;
        bits(1'b1, 2);

        for (int i = 0; i < 12; i++) begin
            v = vt[i];
            o0 = ovr_cnt;
            set_cfg(v.cfg_bits, v.pen, v.podd, v.s2);
            send(v);
            check($sformatf("v%0d_valid", i), int'(bus_if.rx_valid), 1);
            check($sformatf("v%0d_data", i),
                  int'(bus_if.rx_data), int'(v.exp_data));
            check($sformatf("v%0d_perr", i),
                  int'(bus_if.err_parity), int'(v.exp_pe));
            check($sformatf("v%0d_ferr", i),
                  int'(bus_if.err_frame), int'(v.exp_fe));
            check($sformatf("v%0d_ovr", i), ovr_cnt - o0, 0);
            handshake($sformatf("v%0d", i));
        end

        set_cfg(8, 0, 0, 0);
        busy_seen = 0;
        bus_if.rxd = 1'b0;
        repeat (6) @(negedge pclk);
        bus_if.rxd = 1'b1;
        repeat (2 * BITC) @(negedge pclk);
        check("glitch_busy_seen", int'(busy_seen), 1);
        check("glitch_busy_now", int'(bus_if.busy), 0);
        check("glitch_valid", int'(bus_if.rx_valid), 0);

        o0 = ovr_cnt;
        send(mk(8, 8, 9'h011, 0, 0, 0, 0, 2'b00, 9'h011, 0, 0));
        send(mk(8, 8, 9'h022, 0, 0, 0, 0, 2'b00, 9'h022, 0, 0));
        check("ovr_valid", int'(bus_if.rx_valid), 1);
        check("ovr_data", int'(bus_if.rx_data), 'h011);
        check("ovr_pulses", ovr_cnt - o0, 1);
        handshake("ovr");

        b0 = brk_cnt;
        bits(1'b0, 12);
        check("brk_high", int'(bus_if.rx_break), 1);
        check("brk_valid", int'(bus_if.rx_valid), 0);
        bits(1'b1, 2);
        check("brk_low", int'(bus_if.rx_break), 0);
        check("brk_count", brk_cnt - b0, 1);
        check("brk_busy", int'(bus_if.busy), 0);
        send(mk(8, 8, 9'h055, 0, 0, 0, 0, 2'b00, 9'h055, 0, 0));
        check("post_brk_valid", int'(bus_if.rx_valid), 1);
        check("post_brk_data", int'(bus_if.rx_data), 'h055);
        check("post_brk_perr", int'(bus_if.err_parity), 0);
        check("post_brk_ferr", int'(bus_if.err_frame), 0);

        set_cfg(9, 1, 0, 0);
        bits(1'b0, 1);
        bits(1'b0, 1);
        bits(1'b1, 1);
        bits(1'b0, 1);
        bits(1'b1, 1);
        bus_if.rxd = 1'b1;
        repeat (BITC / 2) @(negedge pclk);
        check("en_busy_before", int'(bus_if.busy), 1);
        bus_if.enable = 1'b0;
        @(negedge pclk);
        check("en_busy_after", int'(bus_if.busy), 0);
        bus_if.rxd = 1'b1;
        repeat (BITC) @(negedge pclk);
        bus_if.enable = 1'b1;
        bits(1'b1, 12);
        check("en_busy_idle", int'(bus_if.busy), 0);
        check("en_valid_kept", int'(bus_if.rx_valid), 1);
        check("en_data_kept", int'(bus_if.rx_data), 'h055);
        handshake("en");

`ifdef UART_RX_TIMEOUT_EN
        set_cfg(8, 0, 0, 0);
        send(mk(8, 8, 9'h033, 0, 0, 0, 0, 2'b00, 9'h033, 0, 0));
        check("to_data", int'(bus_if.rx_data), 'h033);
        handshake("to");
        t0 = tout_cnt;
        bits(1'b1, 42);
        check("to_pulse", tout_cnt - t0, 1);
        bits(1'b1, 45);
        check("to_once", tout_cnt - t0, 1);
`else
        t0 = 0;
        check("to_tied", tout_cnt - t0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
